// File: rtl/sc_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice per clock through a registered carry.
// The start/busy/done handshake wraps an IDLE -> RUN -> DONE sequencer.
module sc_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             SC_SERIALADDER_CLOCK_50,
  input  logic             SC_SERIALADDER_RESET_InLow,
  input  logic             SC_SERIALADDER_start_In,
  input  logic             SC_SERIALADDER_sub_In,
  input  logic [WIDTH-1:0] SC_SERIALADDER_a_In,
  input  logic [WIDTH-1:0] SC_SERIALADDER_b_In,
  output logic             SC_SERIALADDER_busy_Out,
  output logic             SC_SERIALADDER_done_Out,
  output logic [WIDTH-1:0] SC_SERIALADDER_sum_Out,
  output logic             SC_SERIALADDER_cout_Out,
  output logic             SC_SERIALADDER_ovf_Out
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_op_a, r_op_b, r_acc, r_sum;
  logic               r_carry, r_cout, r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic [DIGIT:0]     w_slice;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_last, w_accept, w_cin_msb;

  assign w_slice    = {1'b0, r_op_a[DIGIT-1:0]} + {1'b0, r_op_b[DIGIT-1:0]}
                    + (DIGIT+1)'(r_carry);
  // Slice result enters from the MSB end, so after N slices the LSB slice sits at bit 0.
  assign w_acc_next = WIDTH'({w_slice[DIGIT-1:0], r_acc} >> DIGIT);
  assign w_last     = (r_cnt == CNT_W'(N - 1));
  assign w_accept   = (r_state != RUN) && SC_SERIALADDER_start_In;
  // Carry into the top bit of the current slice, recovered from its sum bit.
  assign w_cin_msb  = r_op_a[DIGIT-1] ^ r_op_b[DIGIT-1] ^ w_slice[DIGIT-1];

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update from the same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge SC_SERIALADDER_CLOCK_50 or negedge SC_SERIALADDER_RESET_InLow) begin
    if (!SC_SERIALADDER_RESET_InLow) r_state <= IDLE;
    else                             r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (SC_SERIALADDER_start_In) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = SC_SERIALADDER_start_In ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge SC_SERIALADDER_CLOCK_50 or negedge SC_SERIALADDER_RESET_InLow) begin
    if (!SC_SERIALADDER_RESET_InLow) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1, with the +1 injected as the initial carry.
      r_op_a  <= SC_SERIALADDER_a_In;
      r_op_b  <= SC_SERIALADDER_sub_In ? ~SC_SERIALADDER_b_In : SC_SERIALADDER_b_In;
      r_carry <= SC_SERIALADDER_sub_In;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_op_a  <= r_op_a >> DIGIT;
      r_op_b  <= r_op_b >> DIGIT;
      r_acc   <= w_acc_next;
      r_carry <= w_slice[DIGIT];
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_slice[DIGIT];
        r_ovf  <= w_cin_msb ^ w_slice[DIGIT];
      end
    end
  end

  assign SC_SERIALADDER_busy_Out = (r_state == RUN);
  assign SC_SERIALADDER_done_Out = (r_state == DONE);
  assign SC_SERIALADDER_sum_Out  = r_sum;
  assign SC_SERIALADDER_cout_Out = r_cout;
  assign SC_SERIALADDER_ovf_Out  = r_ovf;

endmodule

// File: tb/tb_sc_serial_adder.sv
// Directed bench for sc_serial_adder at WIDTH=8 with DIGIT=1, 4 and 8 instances
// sharing clock, reset and operand buses; each instance has its own start.
module tb_sc_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start = 3'b000;
  logic       sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       busy_o [3];
  logic       done_o [3];
  logic [7:0] sum_o  [3];
  logic       cout_o [3];
  logic       ovf_o  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .SC_SERIALADDER_CLOCK_50(clk), .SC_SERIALADDER_RESET_InLow(rst_n),
    .SC_SERIALADDER_start_In(start[0]), .SC_SERIALADDER_sub_In(sub),
    .SC_SERIALADDER_a_In(a), .SC_SERIALADDER_b_In(b),
    .SC_SERIALADDER_busy_Out(busy_o[0]), .SC_SERIALADDER_done_Out(done_o[0]),
    .SC_SERIALADDER_sum_Out(sum_o[0]), .SC_SERIALADDER_cout_Out(cout_o[0]),
    .SC_SERIALADDER_ovf_Out(ovf_o[0]));

  sc_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .SC_SERIALADDER_CLOCK_50(clk), .SC_SERIALADDER_RESET_InLow(rst_n),
    .SC_SERIALADDER_start_In(start[1]), .SC_SERIALADDER_sub_In(sub),
    .SC_SERIALADDER_a_In(a), .SC_SERIALADDER_b_In(b),
    .SC_SERIALADDER_busy_Out(busy_o[1]), .SC_SERIALADDER_done_Out(done_o[1]),
    .SC_SERIALADDER_sum_Out(sum_o[1]), .SC_SERIALADDER_cout_Out(cout_o[1]),
    .SC_SERIALADDER_ovf_Out(ovf_o[1]));

  sc_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .SC_SERIALADDER_CLOCK_50(clk), .SC_SERIALADDER_RESET_InLow(rst_n),
    .SC_SERIALADDER_start_In(start[2]), .SC_SERIALADDER_sub_In(sub),
    .SC_SERIALADDER_a_In(a), .SC_SERIALADDER_b_In(b),
    .SC_SERIALADDER_busy_Out(busy_o[2]), .SC_SERIALADDER_done_Out(done_o[2]),
    .SC_SERIALADDER_sum_Out(sum_o[2]), .SC_SERIALADDER_cout_Out(cout_o[2]),
    .SC_SERIALADDER_ovf_Out(ovf_o[2]));

  // Drives one request across the next rising edge; returns #1 after that edge.
  task automatic start_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv);
    a = av; b = bv; sub = sv;
    start[idx] = 1'b1;
    @(posedge clk); #1;
    start[idx] = 1'b0;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Counts edges until done (bounded) and compares latency and result.
  task automatic wait_done(input int idx, input int exp_lat, input logic [7:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf, input string name);
    int lat = 0;
    while (done_o[idx] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (sum_o[idx] !== exp_sum) begin
      errors++; $display("FAIL %s sum: got %h expected %h", name, sum_o[idx], exp_sum);
    end
    checks++;
    if (cout_o[idx] !== exp_cout) begin
      errors++; $display("FAIL %s cout: got %b expected %b", name, cout_o[idx], exp_cout);
    end
    checks++;
    if (ovf_o[idx] !== exp_ovf) begin
      errors++; $display("FAIL %s ovf: got %b expected %b", name, ovf_o[idx], exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    advance(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy_o[i], done_o[i], sum_o[i], cout_o[i], ovf_o[i]} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                 i, busy_o[i], done_o[i], sum_o[i], cout_o[i], ovf_o[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    advance(2);
    checks++;
    if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy_o[0], done_o[0]);
    end
  endtask

  task automatic test_add_d1();
    start_op(0, 8'd100, 8'd27, 1'b0);
    checks++;
    if (busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
      errors++; $display("FAIL busy_in_run: got busy=%b done=%b expected 1 0", busy_o[0], done_o[0]);
    end
    wait_done(0, 8, 8'd127, 1'b0, 1'b0, "add_100_27");
    advance(1);
    checks++;
    if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || sum_o[0] !== 8'd127) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b busy=%b sum=%h expected 0 0 7f",
               done_o[0], busy_o[0], sum_o[0]);
    end
    start_op(0, 8'd127, 8'd1, 1'b0);
    wait_done(0, 8, 8'h80, 1'b0, 1'b1, "add_127_1_ovf");
    start_op(0, 8'd255, 8'd1, 1'b0);
    wait_done(0, 8, 8'h00, 1'b1, 1'b0, "add_255_1_wrap");
  endtask

  task automatic test_sub_d1();
    start_op(0, 8'd5, 8'd7, 1'b1);
    wait_done(0, 8, 8'hFE, 1'b0, 1'b0, "sub_5_7_borrow");
    start_op(0, 8'd0, 8'd0, 1'b1);
    wait_done(0, 8, 8'h00, 1'b1, 1'b0, "sub_0_0");
    start_op(0, 8'h80, 8'd1, 1'b1);
    wait_done(0, 8, 8'h7F, 1'b1, 1'b1, "sub_80_1_ovf");
  endtask

  task automatic test_digit4();
    start_op(1, 8'hF0, 8'h10, 1'b0);
    wait_done(1, 2, 8'h00, 1'b1, 1'b0, "d4_add_f0_10");
    start_op(1, 8'h7F, 8'h01, 1'b0);
    wait_done(1, 2, 8'h80, 1'b0, 1'b1, "d4_add_7f_01_ovf");
  endtask

  task automatic test_digit8();
    start_op(2, 8'hF0, 8'h10, 1'b0);
    wait_done(2, 1, 8'h00, 1'b1, 1'b0, "d8_add_f0_10");
    start_op(2, 8'h80, 8'h01, 1'b1);
    wait_done(2, 1, 8'h7F, 1'b1, 1'b1, "d8_sub_80_01_ovf");
  endtask

  // Previous result on instance 0 is 0x7F; it must hold through RUN.
  task automatic test_ignored_start();
    start_op(0, 8'd10, 8'd20, 1'b0);
    checks++;
    if (sum_o[0] !== 8'h7F) begin
      errors++; $display("FAIL sum_hold_in_run: got %h expected 7f", sum_o[0]);
    end
    advance(2);
    start_op(0, 8'd1, 8'd1, 1'b1);
    checks++;
    if (busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL busy_after_ignored_start: got %b expected 1", busy_o[0]);
    end
    wait_done(0, 5, 8'd30, 1'b0, 1'b0, "ignored_start_keeps_op");
  endtask

  // Instance 0 is in DONE here; a start in this cycle must be accepted.
  task automatic test_back_to_back();
    start_op(0, 8'd50, 8'd25, 1'b1);
    checks++;
    if (busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
      errors++; $display("FAIL start_in_done_accepted: got busy=%b done=%b expected 1 0", busy_o[0], done_o[0]);
    end
    wait_done(0, 8, 8'd25, 1'b1, 1'b0, "back_to_back_sub_50_25");
  endtask

  task automatic test_reset_midrun();
    int seen = 0;
    start_op(0, 8'd100, 8'd27, 1'b0);
    advance(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o[0], done_o[0], sum_o[0], cout_o[0], ovf_o[0]} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset_midrun: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy_o[0], done_o[0], sum_o[0], cout_o[0], ovf_o[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_o[0] === 1'b1 || busy_o[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL no_done_after_reset: got %0d active cycles expected 0", seen);
    end
    start_op(0, 8'd100, 8'd27, 1'b0);
    wait_done(0, 8, 8'd127, 1'b0, 1'b0, "add_after_reset");
  endtask

  initial begin
    test_reset();
    test_add_d1();
    test_sub_d1();
    test_digit4();
    test_digit8();
    test_ignored_start();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
